accum_load_ctrl: RTL and testbench
==================================

ACCUM_LOAD_CTRL -- requirements
Module: accum_load_ctrl

Interface
REQ-001 SHALL have parameter MAX_WIDTH, default 8, data width of operands and accumulator register.
REQ-002 SHALL have parameter MAX_COUNT, default 4, operands per batch (legal range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand offered.
REQ-006 SHALL have port in_ready  output  1  operand accepted when in_valid and in_ready both high at a rising clk edge.
REQ-007 SHALL have port in_data  input  MAX_WIDTH  unsigned operand.
REQ-008 SHALL have port clr_req  input  1  synchronous batch abort/clear command.
REQ-009 SHALL have port ack  input  1  consumer acknowledges completed batch.
REQ-010 SHALL have port reg_q  input  MAX_WIDTH  current value of the downstream enable/sync-clear accumulator register.
REQ-011 SHALL have port reg_d  output  MAX_WIDTH  next value for downstream register.
REQ-012 SHALL have port reg_en  output  1  downstream register load enable.
REQ-013 SHALL have port reg_sclr  output  1  downstream register synchronous clear.
REQ-014 SHALL have ports busy, done, ovf  output  1 each  batch in progress, batch complete, sticky saturation flag.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM, DONE; busy=1 exactly in ACCUM, done=1 exactly in DONE.
REQ-016 SHALL keep an operand counter cnt of width clog2(MAX_COUNT+1), counting accepted operands in the current batch.
REQ-017 SHALL drive in_ready=1 in IDLE and ACCUM when clr_req=0; in_ready=0 in DONE or when clr_req=1.
REQ-018 SHALL, on acceptance in IDLE, drive reg_d=in_data, reg_en=1 (load, no add), set cnt=1, clear ovf, go to ACCUM (DONE if MAX_COUNT=1).
REQ-019 SHALL, on acceptance in ACCUM, drive reg_d=reg_q+in_data with MAX_WIDTH+1-bit sum; on carry-out reg_d=all ones and ovf set (sticky until next batch start, clr_req or rst).
REQ-020 SHALL increment cnt on each ACCUM acceptance and go to DONE in the cycle cnt reaches MAX_COUNT.
REQ-021 SHALL drive reg_en=0 and reg_sclr=0 in every cycle with no acceptance and no clr_req; reg_d=0 then.
REQ-022 SHALL make reg_d, reg_en, reg_sclr combinational (Mealy) so the result appears on reg_q one clk after acceptance; back-to-back acceptances every cycle SHALL be supported.
REQ-023 SHALL hold DONE with reg_en=0 until ack=1, then go to IDLE next edge; ack outside DONE SHALL be ignored.
REQ-024 SHALL give clr_req priority over every other event in any state: reg_sclr=1, reg_en=1, reg_d=0, no operand accepted, cnt=0, ovf=0, next state IDLE.
REQ-025 SHALL keep ovf visible in DONE for the consumer together with the final reg_q.

Reset
REQ-026 SHALL on rst=1 immediately (without clk) force state IDLE, cnt=0, ovf=0, busy=0, done=0.
REQ-027 SHALL hold reg_en=0, reg_sclr=0, reg_d=0, in_ready=0 while rst=1; downstream register shares rst and clears to 0.
REQ-028 SHALL resume normal operation at the first rising clk edge after rst deasserts, starting in IDLE.

Verification (MAX_WIDTH=8, MAX_COUNT=4)
REQ-029 SHALL cover: operands 10,20,30,40 back-to-back -> reg_q=100, done=1 one cycle after last accept, ovf=0.
REQ-030 SHALL cover: batch 200,100,0,0 -> reg_q=255 after second accept, ovf=1 through DONE.
REQ-031 SHALL cover: clr_req with in_valid=1 after two accepts (5,6) -> in_ready=0, reg_sclr=1, reg_q=0 next cycle, state IDLE, cnt=0.
REQ-032 SHALL cover: in DONE with in_valid held 1 -> in_ready=0, reg_q unchanged for 5 cycles; ack=1 -> IDLE, next operand 7 loads reg_q=7.
REQ-033 SHALL cover: async rst asserted mid-edge-free in ACCUM after 1,2 -> busy=0, ovf=0, reg_q=0 before next clk edge.
REQ-034 SHALL cover: in_valid gaps (1,idle,2,idle,idle,3,4) -> reg_q=10, cnt counts only accepted operands.

Source files
------------

// File: rtl/accum_load_ctrl.sv
// Batch accumulate controller: drives the load/clear/next-value pins of an external
// accumulator register, summing MAX_COUNT operands with saturation and a sticky overflow flag.
module accum_load_ctrl #(
   parameter int MAX_WIDTH = 8,
   parameter int MAX_COUNT = 4,
   localparam int CW = $clog2(MAX_COUNT + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [MAX_WIDTH-1:0] in_data,
   input  logic                 clr_req,
   input  logic                 ack,
   input  logic [MAX_WIDTH-1:0] reg_q,
   output logic [MAX_WIDTH-1:0] reg_d,
   output logic                 reg_en,
   output logic                 reg_sclr,
   output logic                 busy,
   output logic                 done,
   output logic                 ovf,
   output logic [1:0]           dbg_state_o,
   output logic [CW-1:0]        dbg_cnt_o
);

   // Handshake: an operand transfers on a rising clk edge where in_valid and in_ready are both 1.
   // in_ready is a pure function of state, clr_req and rst; it never depends on in_valid.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           ovf_q, ovf_d;
   logic [MAX_WIDTH:0] sum;
   logic [CW-1:0]  cnt_inc;
   logic           accept;

   assign sum     = {1'b0, reg_q} + {1'b0, in_data};
   assign cnt_inc = cnt_q + CW'(1);
   assign in_ready = !rst && !clr_req && (state_q != DONE);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      reg_d    = '0;
      reg_en   = 1'b0;
      reg_sclr = 1'b0;
      if (rst) begin
         state_d = IDLE;
      end else if (clr_req) begin
         // Abort outranks acceptance, ack and batch completion alike.
         reg_sclr = 1'b1;
         reg_en   = 1'b1;
         state_d  = IDLE;
         cnt_d    = '0;
         ovf_d    = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  reg_d   = in_data;
                  reg_en  = 1'b1;
                  cnt_d   = CW'(1);
                  ovf_d   = 1'b0;
                  state_d = (MAX_COUNT == 1) ? DONE : ACCUM;
               end
            end
            ACCUM: begin
               if (accept) begin
                  reg_en = 1'b1;
                  if (sum[MAX_WIDTH]) begin
                     reg_d = '1;
                     ovf_d = 1'b1;
                  end else begin
                     reg_d = sum[MAX_WIDTH-1:0];
                  end
                  cnt_d = cnt_inc;
                  if (cnt_inc == CW'(MAX_COUNT)) state_d = DONE;
               end
            end
            DONE: begin
               if (ack) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign busy        = (state_q == ACCUM);
   assign done        = (state_q == DONE);
   assign ovf         = ovf_q;
   assign dbg_state_o = state_q;
   assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_accum_load_ctrl.sv
// Bench for accum_load_ctrl: models the downstream register, predicts every register
// load into a scoreboard queue and checks status flags per scenario.
module tb_accum_load_ctrl;
   localparam int W  = 8;
   localparam int N  = 4;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, clr_req, ack;
   logic [W-1:0]  in_data, reg_q, reg_d;
   logic          reg_en, reg_sclr, busy, done, ovf;
   logic [1:0]    dbg_state;
   logic [CW-1:0] dbg_cnt;

   logic [W-1:0]  exp_q[$];
   int            chk_cnt = 0;
   int            pass_cnt = 0;
   int            m_state, m_cnt;
   logic [W-1:0]  m_acc;
   logic          m_ovf;

   always #5 clk = ~clk;

   accum_load_ctrl #(.MAX_WIDTH(W), .MAX_COUNT(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .clr_req(clr_req), .ack(ack), .reg_q(reg_q), .reg_d(reg_d), .reg_en(reg_en),
      .reg_sclr(reg_sclr), .busy(busy), .done(done), .ovf(ovf),
      .dbg_state_o(dbg_state), .dbg_cnt_o(dbg_cnt)
   );

   // Downstream enable/sync-clear register sharing the async reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           reg_q <= '0;
      else if (reg_sclr) reg_q <= '0;
      else if (reg_en)   reg_q <= reg_d;
   end

   // Scoreboard: every register write must match the oldest prediction
   initial begin
      logic [W-1:0] e;
      forever begin
         @(posedge clk);
         if (reg_en === 1'b1 && rst === 1'b0) begin
            #1;
            chk_cnt++;
            if (exp_q.size() == 0) begin
               $display("FAIL sb_unexpected_load: reg_q=%0d with no prediction", reg_q);
            end else begin
               e = exp_q.pop_front();
               if (reg_q !== e) $display("FAIL sb_reg_q: got %0d expected %0d", reg_q, e);
               else pass_cnt++;
            end
         end
      end
   end

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_ovf = 1'b0; m_acc = '0;
   endtask

   task automatic drive(input logic v, input logic [W-1:0] d, input logic c, input logic a);
      int s;
      @(negedge clk);
      in_valid = v; in_data = d; clr_req = c; ack = a;
      if (c) begin
         model_reset();
         exp_q.push_back('0);
      end else begin
         case (m_state)
            0: if (v) begin
               m_acc = d; m_cnt = 1; m_ovf = 1'b0;
               m_state = (N == 1) ? 2 : 1;
               exp_q.push_back(m_acc);
            end
            1: if (v) begin
               s = int'(m_acc) + int'(d);
               if (s > 255) begin m_acc = 8'hFF; m_ovf = 1'b1; end
               else m_acc = W'(s);
               m_cnt++;
               if (m_cnt == N) m_state = 2;
               exp_q.push_back(m_acc);
            end
            default: if (a) m_state = 0;
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic step(input logic v, input logic [W-1:0] d, input logic c, input logic a);
      drive(v, d, c, a);
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_data = 8'd5; clr_req = 1'b0; ack = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      chk_cnt++; if ({busy, done, ovf} !== 3'b000) $display("FAIL rst_flags: got %b expected 000", {busy, done, ovf}); else pass_cnt++;
      chk_cnt++; if ({in_ready, reg_en, reg_sclr} !== 3'b000) $display("FAIL rst_ctrl: got %b expected 000", {in_ready, reg_en, reg_sclr}); else pass_cnt++;
      chk_cnt++; if (reg_d !== 8'd0 || reg_q !== 8'd0) $display("FAIL rst_data: reg_d=%0d reg_q=%0d expected 0", reg_d, reg_q); else pass_cnt++;
      chk_cnt++; if (dbg_state !== 2'd0 || dbg_cnt !== 3'd0) $display("FAIL rst_state: state=%0d cnt=%0d expected 0", dbg_state, dbg_cnt); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] ops [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, ops[i], 1'b0, 1'b0);
         chk_cnt++; if (dbg_cnt !== CW'(i + 1)) $display("FAIL b2b_cnt: got %0d expected %0d", dbg_cnt, i + 1); else pass_cnt++;
      end
      chk_cnt++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_done: done=%b busy=%b expected 1/0", done, busy); else pass_cnt++;
      chk_cnt++; if (reg_q !== 8'd100 || ovf !== 1'b0) $display("FAIL b2b_result: reg_q=%0d ovf=%b expected 100/0", reg_q, ovf); else pass_cnt++;
      step(1'b0, 8'd0, 1'b0, 1'b1);
      chk_cnt++; if (dbg_state !== 2'd0 || done !== 1'b0) $display("FAIL b2b_ack: state=%0d done=%b expected 0/0", dbg_state, done); else pass_cnt++;
   endtask

   task automatic test_saturate();
      logic [W-1:0] ops [4] = '{8'd200, 8'd100, 8'd0, 8'd0};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, ops[i], 1'b0, 1'b0);
         if (i == 1) begin
            chk_cnt++; if (reg_q !== 8'd255 || ovf !== 1'b1) $display("FAIL sat_clip: reg_q=%0d ovf=%b expected 255/1", reg_q, ovf); else pass_cnt++;
         end
      end
      chk_cnt++; if (done !== 1'b1 || ovf !== 1'b1 || reg_q !== 8'd255) $display("FAIL sat_done: done=%b ovf=%b reg_q=%0d expected 1/1/255", done, ovf, reg_q); else pass_cnt++;
      step(1'b0, 8'd0, 1'b0, 1'b1);
      chk_cnt++; if (ovf !== 1'b1) $display("FAIL sat_sticky_idle: ovf=%b expected 1", ovf); else pass_cnt++;
      step(1'b1, 8'd3, 1'b0, 1'b0);
      chk_cnt++; if (ovf !== 1'b0) $display("FAIL sat_new_batch: ovf=%b expected 0", ovf); else pass_cnt++;
      step(1'b0, 8'd0, 1'b1, 1'b0);
   endtask

   task automatic test_clear();
      step(1'b1, 8'd5, 1'b0, 1'b0);
      step(1'b1, 8'd6, 1'b0, 1'b0);
      drive(1'b1, 8'd9, 1'b1, 1'b0);
      #1;
      chk_cnt++; if ({in_ready, reg_sclr, reg_en} !== 3'b011) $display("FAIL clr_ctrl: rdy/sclr/en=%b expected 011", {in_ready, reg_sclr, reg_en}); else pass_cnt++;
      chk_cnt++; if (reg_d !== 8'd0) $display("FAIL clr_reg_d: got %0d expected 0", reg_d); else pass_cnt++;
      tick();
      chk_cnt++; if (reg_q !== 8'd0 || dbg_state !== 2'd0 || dbg_cnt !== 3'd0 || busy !== 1'b0) $display("FAIL clr_after: reg_q=%0d state=%0d cnt=%0d busy=%b expected 0/0/0/0", reg_q, dbg_state, dbg_cnt, busy); else pass_cnt++;
   endtask

   task automatic test_done_hold();
      for (int i = 0; i < 4; i++) step(1'b1, 8'd1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'd99, 1'b0, 1'b0);
         #1;
         chk_cnt++; if (in_ready !== 1'b0 || reg_en !== 1'b0) $display("FAIL hold_ctrl: in_ready=%b reg_en=%b expected 0/0", in_ready, reg_en); else pass_cnt++;
         tick();
         chk_cnt++; if (reg_q !== 8'd4 || done !== 1'b1) $display("FAIL hold_value: reg_q=%0d done=%b expected 4/1", reg_q, done); else pass_cnt++;
      end
      step(1'b1, 8'd99, 1'b0, 1'b1);
      chk_cnt++; if (dbg_state !== 2'd0 || done !== 1'b0 || reg_q !== 8'd4) $display("FAIL hold_ack: state=%0d done=%b reg_q=%0d expected 0/0/4", dbg_state, done, reg_q); else pass_cnt++;
      step(1'b1, 8'd7, 1'b0, 1'b0);
      chk_cnt++; if (reg_q !== 8'd7 || busy !== 1'b1) $display("FAIL hold_reload: reg_q=%0d busy=%b expected 7/1", reg_q, busy); else pass_cnt++;
      step(1'b0, 8'd0, 1'b1, 1'b0);
   endtask

   task automatic test_async_reset();
      logic [W-1:0] pa [2] = '{8'd1, 8'd200};
      logic [W-1:0] pb [2] = '{8'd2, 8'd100};
      for (int k = 0; k < 2; k++) begin
         step(1'b1, pa[k], 1'b0, 1'b0);
         step(1'b1, pb[k], 1'b0, 1'b0);
         chk_cnt++; if (busy !== 1'b1 || ovf !== m_ovf) $display("FAIL arst_pre: busy=%b ovf=%b expected 1/%b", busy, ovf, m_ovf); else pass_cnt++;
         @(negedge clk);
         in_valid = 1'b1; in_data = 8'd9;
         #2 rst = 1'b1;
         #1;
         chk_cnt++; if ({busy, done, ovf, in_ready} !== 4'b0000) $display("FAIL arst_flags: busy/done/ovf/rdy=%b expected 0000", {busy, done, ovf, in_ready}); else pass_cnt++;
         chk_cnt++; if (reg_q !== 8'd0 || dbg_cnt !== 3'd0 || reg_en !== 1'b0) $display("FAIL arst_data: reg_q=%0d cnt=%0d reg_en=%b expected 0/0/0", reg_q, dbg_cnt, reg_en); else pass_cnt++;
         @(negedge clk);
         rst = 1'b0; in_valid = 1'b0;
         model_reset();
      end
      step(1'b1, 8'd3, 1'b0, 1'b0);
      chk_cnt++; if (busy !== 1'b1 || dbg_cnt !== 3'd1) $display("FAIL arst_resume: busy=%b cnt=%0d expected 1/1", busy, dbg_cnt); else pass_cnt++;
      step(1'b0, 8'd0, 1'b1, 1'b0);
   endtask

   task automatic test_gaps();
      logic [W-1:0] ops [7] = '{8'd1, 8'd0, 8'd2, 8'd0, 8'd0, 8'd3, 8'd4};
      logic         vld [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 7; i++) begin
         step(vld[i], ops[i], 1'b0, (i == 3));
         chk_cnt++; if (dbg_cnt !== CW'(m_cnt)) $display("FAIL gap_cnt: step %0d got %0d expected %0d", i, dbg_cnt, m_cnt); else pass_cnt++;
      end
      chk_cnt++; if (reg_q !== 8'd10 || done !== 1'b1) $display("FAIL gap_result: reg_q=%0d done=%b expected 10/1", reg_q, done); else pass_cnt++;
      step(1'b0, 8'd0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, 2)) step(1'b0, 8'd0, 1'b0, 1'b0);
            step(1'b1, W'($urandom_range(0, 120)), 1'b0, 1'b0);
         end
         chk_cnt++; if (done !== 1'b1 || ovf !== m_ovf || reg_q !== m_acc) $display("FAIL rnd_batch%0d: done=%b ovf=%b reg_q=%0d expected 1/%b/%0d", b, done, ovf, reg_q, m_ovf, m_acc); else pass_cnt++;
         step(1'b0, 8'd0, 1'b0, 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_saturate();
      test_clear();
      test_done_hold();
      test_async_reset();
      test_gaps();
      test_random();
      repeat (2) tick();
      chk_cnt++; if (exp_q.size() != 0) $display("FAIL sb_leftover: %0d predictions never observed", exp_q.size()); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
